// File: rtl/fab_clk_gen_pkg.sv
// Shared types and defaults for the fabric clock generator.
// Optional feature macro used by this block: CLKGEN_PHASE_EN.
package fab_clk_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ch_state_t;

    localparam int DEF_DIV_DFLT     = 4;
    localparam int LOCK_CYCLES_DFLT = 8;

endpackage

// File: rtl/fab_clk_gen_ch.sv
// One divided-clock channel: run/drain FSM, period counter, shadowed divisor, CLK_OUT.
// With CLKGEN_PHASE_EN defined, a start phase is stored per write and loaded on IDLE->RUN.
module fab_clk_gen_ch
    import fab_clk_gen_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = DEF_DIV_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] div_val,
`ifdef CLKGEN_PHASE_EN
    input  logic [DIV_W-1:0] phase_val,
`endif
    output logic             tick,
    output logic             clk_out,
    output logic             ok
);

    ch_state_t        state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] shadow_reg;
    logic [DIV_W-1:0] start_cnt;
    logic             pending_reg;
    logic             clk_out_reg;

`ifdef CLKGEN_PHASE_EN
    logic [DIV_W-1:0] phase_reg;

    // Writes are only forwarded with a non-zero divisor, so the modulo is safe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (wr) begin
            phase_reg <= phase_val % div_val;
        end
    end

    assign start_cnt = phase_reg;
`else
    assign start_cnt = '0;
`endif

    assign tick    = (state_reg != ST_IDLE) && (cnt_reg == div_reg - DIV_W'(1));
    assign clk_out = clk_out_reg;
    assign ok      = !pending_reg && (state_reg != ST_DRAIN) && (!en || (state_reg == ST_RUN));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (en) state_next = ST_RUN;
            ST_RUN:   if (!en) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (en) begin
                    state_next = ST_RUN;
                end else if (tick) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            div_reg     <= DIV_W'(DEF_DIV);
            shadow_reg  <= DIV_W'(DEF_DIV);
            pending_reg <= 1'b0;
            clk_out_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE) begin
                cnt_reg     <= en ? start_cnt : '0;
                clk_out_reg <= 1'b0;
            end else if (tick) begin
                // Period boundary: the only point where a new divisor may take effect.
                cnt_reg     <= '0;
                div_reg     <= shadow_reg;
                pending_reg <= 1'b0;
                clk_out_reg <= (state_next == ST_IDLE) ? 1'b0 : ~clk_out_reg;
            end else begin
                cnt_reg <= cnt_reg + DIV_W'(1);
            end
            if (wr) begin
                shadow_reg <= div_val;
                if (state_reg == ST_IDLE) begin
                    div_reg <= div_val;
                end else begin
                    pending_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fab_clk_gen.sv
// Multi-channel fabric clock/tick generator: write decode, channel array and LOCK.
// Optional start-phase support is enabled by defining CLKGEN_PHASE_EN.
module fab_clk_gen
    import fab_clk_gen_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 16,
    parameter int DEF_DIV     = DEF_DIV_DFLT,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DFLT,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              fab_clk,
    input  logic              fab_reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [DIV_W-1:0]  div_val,
`ifdef CLKGEN_PHASE_EN
    input  logic [DIV_W-1:0]  phase_val,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic              lock
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    logic              wr_ok;
    logic              stable;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] ch_ok;
    logic [NUM_CH-1:0] en_prev_reg;
    logic [LCW-1:0]    stable_cnt_reg;
    logic              lock_reg;

    assign wr_ok = div_wr && (div_val != '0) && ({1'b0, div_ch} < (CH_W + 1)'(NUM_CH));

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_wr[gi] = wr_ok && (div_ch == CH_W'(gi));

        fab_clk_gen_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk       (fab_clk),
            .rst_n     (fab_reset_n),
            .en        (ch_en[gi]),
            .wr        (ch_wr[gi]),
            .div_val   (div_val),
`ifdef CLKGEN_PHASE_EN
            .phase_val (phase_val),
`endif
            .tick      (tick[gi]),
            .clk_out   (clk_out[gi]),
            .ok        (ch_ok[gi])
        );
    end

    // An accepted write or an enable edge restarts the stability window.
    assign stable = (&ch_ok) && !wr_ok && (ch_en == en_prev_reg);
    assign lock   = lock_reg;

    always_ff @(posedge fab_clk) begin
        if (!fab_reset_n) begin
            en_prev_reg    <= '0;
            stable_cnt_reg <= '0;
            lock_reg       <= 1'b0;
        end else begin
            en_prev_reg <= ch_en;
            if (!stable) begin
                stable_cnt_reg <= '0;
                lock_reg       <= 1'b0;
            end else begin
                if (stable_cnt_reg != LCW'(LOCK_CYCLES)) begin
                    stable_cnt_reg <= stable_cnt_reg + LCW'(1);
                end
                lock_reg <= (stable_cnt_reg >= LCW'(LOCK_CYCLES - 1));
            end
        end
    end

endmodule

// File: tb/tb_fab_clk_gen.sv
// Self-checking bench for fab_clk_gen; tick spacing on channel 0 is checked by a scoreboard.
// The phase scenario only runs when CLKGEN_PHASE_EN is defined.
module tb_fab_clk_gen;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 16;
    localparam int DEF_DIV     = 4;
    localparam int LOCK_CYCLES = 8;

    logic              clk;
    logic              fab_reset_n;
    logic [NUM_CH-1:0] ch_en;
    logic              div_wr;
    logic [1:0]        div_ch;
    logic [DIV_W-1:0]  div_val;
`ifdef CLKGEN_PHASE_EN
    logic [DIV_W-1:0]  phase_val;
`endif
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;
    logic              lock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_tick0 = 0;
    int exp_q0[$];

    fab_clk_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEF_DIV     (DEF_DIV),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .fab_clk     (clk),
        .fab_reset_n (fab_reset_n),
        .ch_en       (ch_en),
        .div_wr      (div_wr),
        .div_ch      (div_ch),
        .div_val     (div_val),
`ifdef CLKGEN_PHASE_EN
        .phase_val   (phase_val),
`endif
        .tick        (tick),
        .clk_out     (clk_out),
        .lock        (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each channel-0 tick pops the expected spacing from the previous tick.
    always @(negedge clk) begin
        int exp_sp;
        cyc = cyc + 1;
        if (tick[0] === 1'b1) begin
            if (exp_q0.size() > 0) begin
                exp_sp = exp_q0.pop_front();
                checks++;
                if ((cyc - last_tick0) !== exp_sp) begin
                    errors++;
                    $display("FAIL tick_spacing_ch0: got %0d cycles, expected %0d (cycle %0d)",
                             cyc - last_tick0, exp_sp, cyc);
                end else begin
                    $display("tick ch0 at cycle %0d spacing %0d ok", cyc, exp_sp);
                end
            end
            last_tick0 = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        fab_reset_n = 1'b0;
        ch_en       = '0;
        div_wr      = 1'b1;    // a write during reset must be discarded
        div_ch      = 2'd0;
        div_val     = 16'd9;
        step(3);
        checks++;
        if (tick !== 3'b000) begin
            errors++; $display("FAIL reset_tick: got %b expected 000", tick);
        end
        checks++;
        if (clk_out !== 3'b000) begin
            errors++; $display("FAIL reset_clk_out: got %b expected 000", clk_out);
        end
        checks++;
        if (lock !== 1'b0) begin
            errors++; $display("FAIL reset_lock: got %b expected 0", lock);
        end
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_idle_lock;
        int n;
        div_wr      = 1'b0;
        fab_reset_n = 1'b1;
        n = cyc;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (lock === 1'b1) break;
        end
        checks++;
        if ((cyc - n) !== LOCK_CYCLES) begin
            errors++; $display("FAIL idle_lock_latency: got %0d expected %0d", cyc - n, LOCK_CYCLES);
        end
        $display("test_idle_lock: lock after %0d cycles", cyc - n);
    endtask

    task automatic test_basic;
        int n;
        int toggles;
        logic prev;
        last_tick0 = cyc;
        n = cyc;
        ch_en = 3'b001;
        for (int k = 0; k < 4; k++) exp_q0.push_back(DEF_DIV);
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (lock === 1'b1) break;
        end
        checks++;
        if ((cyc - n) !== 1 + LOCK_CYCLES) begin
            errors++; $display("FAIL basic_lock_latency: got %0d expected %0d", cyc - n, 1 + LOCK_CYCLES);
        end
        for (int k = 0; k < 60 && exp_q0.size() > 0; k++) step(1);
        checks++;
        if (exp_q0.size() !== 0) begin
            errors++; $display("FAIL basic_drain: got %0d pending ticks expected 0", exp_q0.size());
        end
        toggles = 0;
        prev = clk_out[0];
        for (int k = 0; k < 16; k++) begin
            step(1);
            if (clk_out[0] !== prev) toggles++;
            prev = clk_out[0];
        end
        checks++;
        if (toggles !== 16 / DEF_DIV) begin
            errors++; $display("FAIL basic_clk_out_toggles: got %0d expected %0d", toggles, 16 / DEF_DIV);
        end
        $display("test_basic done at cycle %0d", cyc);
    endtask

    task automatic test_div_update;
        int t;
        for (int k = 0; k < 20 && tick[0] !== 1'b1; k++) step(1);
        t = cyc;
        checks++;
        if (lock !== 1'b1) begin
            errors++; $display("FAIL update_lock_before: got %b expected 1", lock);
        end
        exp_q0.push_back(4);
        exp_q0.push_back(6);
        exp_q0.push_back(6);
        step(1);
        div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd9;
        step(1);
        checks++;
        if (lock !== 1'b0) begin
            errors++; $display("FAIL update_lock_drop: got %b expected 0", lock);
        end
        div_val = 16'd6;    // overwrites the still-pending 9
        step(1);
        div_wr = 1'b0;
        for (int k = 0; k < 40 && lock !== 1'b1; k++) step(1);
        checks++;
        if (cyc !== t + 4 + 1 + LOCK_CYCLES) begin
            errors++; $display("FAIL update_lock_return: got cycle %0d expected %0d", cyc, t + 5 + LOCK_CYCLES);
        end
        for (int k = 0; k < 60 && exp_q0.size() > 0; k++) step(1);
        checks++;
        if (exp_q0.size() !== 0) begin
            errors++; $display("FAIL update_drain: got %0d pending ticks expected 0", exp_q0.size());
        end
        $display("test_div_update done at cycle %0d", cyc);
    endtask

    task automatic test_ignored_writes;
        int drops;
        for (int k = 0; k < 20 && tick[0] !== 1'b1; k++) step(1);
        for (int k = 0; k < 3; k++) exp_q0.push_back(6);
        drops = 0;
        step(1);
        div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd0;
        step(1);
        div_ch = 2'd3; div_val = 16'd2;
        step(1);
        div_wr = 1'b0; div_ch = 2'd0;
        for (int k = 0; k < 20; k++) begin
            if (lock !== 1'b1) drops++;
            step(1);
        end
        checks++;
        if (drops !== 0) begin
            errors++; $display("FAIL ignored_lock_hold: got %0d cycles without lock expected 0", drops);
        end
        checks++;
        if (exp_q0.size() !== 0) begin
            errors++; $display("FAIL ignored_drain: got %0d pending ticks expected 0", exp_q0.size());
        end
        $display("test_ignored_writes done at cycle %0d", cyc);
    endtask

    task automatic test_drain;
        int rise;
        int fall;
        int bad;
        logic prev;
        bit found;
        div_wr = 1'b1; div_ch = 2'd1; div_val = 16'd5;
        step(1);
        div_wr = 1'b0;
        ch_en  = 3'b011;
        found = 0;
        rise = 0;
        prev = clk_out[1];
        for (int k = 0; k < 40 && !found; k++) begin
            step(1);
            if (prev === 1'b0 && clk_out[1] === 1'b1) begin
                found = 1;
                rise = cyc;
            end
            prev = clk_out[1];
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL drain_rise: got no rising edge on clk_out[1] expected one");
        end
        step(2);
        ch_en = 3'b001;
        for (int k = 0; k < 20 && clk_out[1] !== 1'b0; k++) step(1);
        fall = cyc;
        checks++;
        if (fall - rise !== 5) begin
            errors++; $display("FAIL drain_high_len: got %0d expected 5", fall - rise);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (clk_out[1] !== 1'b0 || tick[1] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL drain_stays_idle: got %0d active samples expected 0", bad);
        end
        $display("test_drain done at cycle %0d", cyc);
    endtask

    task automatic test_n1_and_reset;
        int bad_t;
        int bad_c;
        logic prev;
        div_wr = 1'b1; div_ch = 2'd2; div_val = 16'd1;
        step(1);
        div_wr = 1'b0;
        ch_en  = 3'b101;
        step(2);
        bad_t = 0;
        bad_c = 0;
        for (int k = 0; k < 8; k++) begin
            prev = clk_out[2];
            step(1);
            if (tick[2] !== 1'b1) bad_t++;
            if (clk_out[2] === prev) bad_c++;
        end
        checks++;
        if (bad_t !== 0) begin
            errors++; $display("FAIL n1_tick_const: got %0d low samples expected 0", bad_t);
        end
        checks++;
        if (bad_c !== 0) begin
            errors++; $display("FAIL n1_clk_toggle: got %0d missed toggles expected 0", bad_c);
        end
        fab_reset_n = 1'b0;
        div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd2;    // must lose to reset
        step(1);
        checks++;
        if (tick !== 3'b000) begin
            errors++; $display("FAIL midreset_tick: got %b expected 000", tick);
        end
        checks++;
        if (clk_out !== 3'b000) begin
            errors++; $display("FAIL midreset_clk_out: got %b expected 000", clk_out);
        end
        checks++;
        if (lock !== 1'b0) begin
            errors++; $display("FAIL midreset_lock: got %b expected 0", lock);
        end
        fab_reset_n = 1'b1;
        div_wr = 1'b0;
        ch_en  = 3'b001;
        last_tick0 = cyc;
        exp_q0.push_back(DEF_DIV);
        exp_q0.push_back(DEF_DIV);
        for (int k = 0; k < 40 && exp_q0.size() > 0; k++) step(1);
        checks++;
        if (exp_q0.size() !== 0) begin
            errors++; $display("FAIL midreset_drain: got %0d pending ticks expected 0", exp_q0.size());
        end
        $display("test_n1_and_reset done at cycle %0d", cyc);
    endtask

`ifdef CLKGEN_PHASE_EN
    task automatic test_phase;
        int t0;
        int t1;
        fab_reset_n = 1'b0;
        ch_en = '0;
        phase_val = '0;
        step(2);
        fab_reset_n = 1'b1;
        div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd4; phase_val = 16'd0;
        step(1);
        div_ch = 2'd1; phase_val = 16'd2;
        step(1);
        div_wr = 1'b0;
        ch_en  = 3'b011;
        t0 = -1;
        t1 = -1;
        for (int k = 0; k < 20 && (t0 < 0 || t1 < 0); k++) begin
            step(1);
            if (tick[0] === 1'b1 && t0 < 0) t0 = cyc;
            if (tick[1] === 1'b1 && t1 < 0) t1 = cyc;
        end
        checks++;
        if (t0 - t1 !== 2 || t0 < 0 || t1 < 0) begin
            errors++; $display("FAIL phase_lead: got %0d expected 2", t0 - t1);
        end
        $display("test_phase: ch1 leads ch0 by %0d", t0 - t1);
    endtask
`endif

    initial begin
        test_reset();
        test_idle_lock();
        test_basic();
        test_div_update();
        test_ignored_writes();
        test_drain();
        test_n1_and_reset();
`ifdef CLKGEN_PHASE_EN
        test_phase();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
